// File: rtl/cci_mpf_prim_ram_byteena_arb.sv
// rtl/cci_mpf_prim_ram_byteena_arb.sv - two-requester round-robin arbiter over one byte-enabled RAM port
// Clears the RAM to INIT_VALUE after reset, then serializes requester accesses on port 0.

module cci_mpf_prim_ram_dualport_byteena #(
    parameter int N_ENTRIES           = 32,
    parameter int N_DATA_BITS         = 64,
    parameter int N_BYTE_BITS         = 8,
    parameter int N_OUTPUT_REG_STAGES = 0
) (
    input  logic                                  clk,
    input  logic                                  wen0,
    input  logic [$clog2(N_ENTRIES)-1:0]          addr0,
    input  logic [N_DATA_BITS/N_BYTE_BITS-1:0]    byteena0,
    input  logic [N_DATA_BITS-1:0]                wdata0,
    output logic [N_DATA_BITS-1:0]                rdata0,
    input  logic                                  wen1,
    input  logic [$clog2(N_ENTRIES)-1:0]          addr1,
    input  logic [N_DATA_BITS/N_BYTE_BITS-1:0]    byteena1,
    input  logic [N_DATA_BITS-1:0]                wdata1
);
    localparam int NB = N_DATA_BITS / N_BYTE_BITS;
    localparam int L  = 1 + N_OUTPUT_REG_STAGES;

    logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
    logic [N_DATA_BITS-1:0] rd_q [L];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wen0 && byteena0[b]) begin
                mem[addr0][b*N_BYTE_BITS +: N_BYTE_BITS] <= wdata0[b*N_BYTE_BITS +: N_BYTE_BITS];
            end
            if (wen1 && byteena1[b]) begin
                mem[addr1][b*N_BYTE_BITS +: N_BYTE_BITS] <= wdata1[b*N_BYTE_BITS +: N_BYTE_BITS];
            end
        end
        // Read returns the pre-write contents of the addressed entry.
        rd_q[0] <= mem[addr0];
        for (int s = 1; s < L; s++) begin
            rd_q[s] <= rd_q[s-1];
        end
    end

    assign rdata0 = rd_q[L-1];
endmodule

module cci_mpf_prim_ram_byteena_arb #(
    parameter int                      N_ENTRIES           = 32,
    parameter int                      N_DATA_BITS         = 64,
    parameter int                      N_BYTE_BITS         = 8,
    parameter int                      N_OUTPUT_REG_STAGES = 0,
    parameter logic [N_DATA_BITS-1:0]  INIT_VALUE          = N_DATA_BITS'(0)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    output logic                                  rdy,
    input  logic [1:0]                            req_valid,
    output logic [1:0]                            req_ready,
    input  logic [1:0]                            req_wen,
    input  logic [$clog2(N_ENTRIES)-1:0]          req_addr [2],
    input  logic [N_DATA_BITS/N_BYTE_BITS-1:0]    req_byteena [2],
    input  logic [N_DATA_BITS-1:0]                req_wdata [2],
    output logic [1:0]                            rsp_valid,
    output logic [N_DATA_BITS-1:0]                rsp_rdata [2]
);
    localparam int AW = $clog2(N_ENTRIES);
    localparam int NB = N_DATA_BITS / N_BYTE_BITS;
    localparam int L  = 1 + N_OUTPUT_REG_STAGES;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   init_addr_q, init_addr_d;
    logic            fav_q, fav_d;
    logic [L-1:0]    rsp_v_q, rsp_v_d;
    logic [L-1:0]    rsp_id_q, rsp_id_d;

    logic [1:0]             grant;
    logic                   sel;
    logic                   rd_fire;
    logic                   ram_wen;
    logic [AW-1:0]          ram_addr;
    logic [NB-1:0]          ram_byteena;
    logic [N_DATA_BITS-1:0] ram_wdata;
    logic [N_DATA_BITS-1:0] ram_rdata;

    assign rdy = (state_q == ST_RUN);

    always_comb begin
        grant = 2'b00;
        if (rdy) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = fav_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign sel       = grant[1];
    assign rd_fire   = (|grant) && !req_wen[sel];

    always_comb begin
        ram_wen     = 1'b1;
        ram_addr    = init_addr_q;
        ram_byteena = '1;
        ram_wdata   = INIT_VALUE;
        if (rdy) begin
            ram_wen     = (|grant) && req_wen[sel];
            ram_addr    = req_addr[sel];
            ram_byteena = req_byteena[sel];
            ram_wdata   = req_wdata[sel];
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        fav_d       = fav_q;
        if (state_q == ST_INIT) begin
            init_addr_d = init_addr_q + AW'(1);
            if (init_addr_q == AW'(N_ENTRIES - 1)) begin
                state_d = ST_RUN;
            end
        end
        if (grant[0]) fav_d = 1'b1;
        if (grant[1]) fav_d = 1'b0;
    end

    // Requester tag rides alongside the RAM read pipeline so data lands on the right rsp_valid.
    always_comb begin
        rsp_v_d     = '0;
        rsp_id_d    = '0;
        rsp_v_d[0]  = rd_fire;
        rsp_id_d[0] = sel;
        for (int s = 1; s < L; s++) begin
            rsp_v_d[s]  = rsp_v_q[s-1];
            rsp_id_d[s] = rsp_id_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            fav_q       <= 1'b0;
            rsp_v_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            fav_q       <= fav_d;
            rsp_v_q     <= rsp_v_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid[0] = rsp_v_q[L-1] && !rsp_id_q[L-1];
    assign rsp_valid[1] = rsp_v_q[L-1] &&  rsp_id_q[L-1];
    assign rsp_rdata[0] = ram_rdata;
    assign rsp_rdata[1] = ram_rdata;

    cci_mpf_prim_ram_dualport_byteena #(
        .N_ENTRIES           (N_ENTRIES),
        .N_DATA_BITS         (N_DATA_BITS),
        .N_BYTE_BITS         (N_BYTE_BITS),
        .N_OUTPUT_REG_STAGES (N_OUTPUT_REG_STAGES)
    ) u_ram (
        .clk      (clk),
        .wen0     (ram_wen),
        .addr0    (ram_addr),
        .byteena0 (ram_byteena),
        .wdata0   (ram_wdata),
        .rdata0   (ram_rdata),
        .wen1     (1'b0),
        .addr1    ('0),
        .byteena1 ('0),
        .wdata1   ('0)
    );
endmodule

// File: tb/tb_cci_mpf_prim_ram_byteena_arb.sv
// tb/tb_cci_mpf_prim_ram_byteena_arb.sv - scoreboard bench for the byte-enabled RAM arbiter
module tb_cci_mpf_prim_ram_byteena_arb;
    localparam int          N       = 32;
    localparam int          L       = 3;
    localparam logic [63:0] INIT_V  = {8{8'hA5}};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rdy;
    logic [1:0]  req_valid, req_ready, req_wen;
    logic [4:0]  req_addr [2];
    logic [7:0]  req_byteena [2];
    logic [63:0] req_wdata [2];
    logic [1:0]  rsp_valid;
    logic [63:0] rsp_rdata [2];

    always #5 clk = ~clk;

    cci_mpf_prim_ram_byteena_arb #(
        .N_ENTRIES(N), .N_DATA_BITS(64), .N_BYTE_BITS(8),
        .N_OUTPUT_REG_STAGES(2), .INIT_VALUE(INIT_V)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rdy(rdy),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_byteena(req_byteena), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    typedef struct {
        int          id;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mem_m [N];
    int          cyc = 0;
    int          init_cnt = 0;
    logic        fav_m = 1'b0;
    logic [1:0]  last_g;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check grant/rdy, update the model, cross the edge, check responses.
    task automatic tick();
        logic [1:0] g;
        logic [1:0] exp_v;
        logic       rdy_m;
        #1;
        rdy_m = (init_cnt == N);
        g = 2'b00;
        if (rdy_m) begin
            if (req_valid == 2'b11) g[fav_m] = 1'b1;
            else g = req_valid;
        end
        check("rdy", 64'(rdy), 64'(rdy_m));
        check("req_ready", 64'(req_ready), 64'(g));
        for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
                if (req_wen[i]) begin
                    for (int b = 0; b < 8; b++)
                        if (req_byteena[i][b]) mem_m[req_addr[i]][b*8 +: 8] = req_wdata[i][b*8 +: 8];
                end else begin
                    sb.push_back('{i, mem_m[req_addr[i]], cyc + L});
                end
                fav_m = (i == 0);
            end
        end
        last_g = g;
        @(posedge clk);
        if (!reset_n) begin
            init_cnt = 0;
            fav_m    = 1'b0;
            sb.delete();
            for (int a = 0; a < N; a++) mem_m[a] = INIT_V;
        end else if (init_cnt < N) begin
            init_cnt++;
        end
        @(negedge clk);
        exp_v = 2'b00;
        if (sb.size() != 0 && sb[0].due == cyc) exp_v[sb[0].id] = 1'b1;
        check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        if (exp_v != 2'b00) begin
            check($sformatf("rsp_rdata%0d", sb[0].id), rsp_rdata[sb[0].id], sb[0].data);
            void'(sb.pop_front());
        end
    endtask

    task automatic issue(input int id, input logic w, input logic [4:0] a,
                         input logic [7:0] be, input logic [63:0] d);
        req_valid       = 2'b00;
        req_valid[id]   = 1'b1;
        req_wen[id]     = w;
        req_addr[id]    = a;
        req_byteena[id] = be;
        req_wdata[id]   = d;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_g[id]) break;
        end
        if (!last_g[id]) check("accept_timeout", 64'd0, 64'd1);
        req_valid = 2'b00;
    endtask

    task automatic wait_init();
        int n_init;
        for (n_init = 0; n_init < 40 && init_cnt != N; n_init++) tick();
        check("init_edges", 64'(n_init), 64'(N));
    endtask

    task automatic drain();
        req_valid = 2'b00;
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_wen   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_addr[i] = '0; req_byteena[i] = '0; req_wdata[i] = '0;
        end
        for (int a = 0; a < N; a++) mem_m[a] = INIT_V;
        @(posedge clk);
        @(negedge clk);
        tick();
        tick();

        // Init sweep with both requesters pending; none may be readied.
        reset_n     = 1'b1;
        req_valid   = 2'b11;
        req_addr[0] = 5'd0;
        req_addr[1] = 5'd1;
        wait_init();
        req_valid = 2'b00;
        for (int a = 0; a < N; a++) issue(0, 1'b0, 5'(a), 8'h00, 64'h0);

        // Basic latency
        issue(0, 1'b1, 5'd5, 8'hFF, 64'h1122334455667788);
        issue(0, 1'b0, 5'd5, 8'h00, 64'h0);

        // Byte enable
        issue(0, 1'b1, 5'd7, 8'hFF, {64{1'b1}});
        issue(0, 1'b1, 5'd7, 8'h0F, 64'h0);
        issue(1, 1'b0, 5'd7, 8'h00, 64'h0);

        // Cross-requester RAW
        issue(1, 1'b1, 5'd3, 8'hFF, 64'h77);
        issue(0, 1'b0, 5'd3, 8'h00, 64'h0);
        drain();

        // Contention: pointer favors requester 0 after a requester-1 grant
        issue(1, 1'b0, 5'd0, 8'h00, 64'h0);
        req_wen     = 2'b00;
        req_addr[0] = 5'd8;
        req_addr[1] = 5'd16;
        req_valid   = 2'b11;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("alternate", 64'(last_g), (k % 2 == 0) ? 64'd1 : 64'd2);
            if (last_g[0]) req_addr[0] = req_addr[0] + 5'd1;
            if (last_g[1]) req_addr[1] = req_addr[1] + 5'd1;
        end
        drain();

        // Reset with reads in flight
        req_valid   = 2'b01;
        req_wen     = 2'b00;
        for (int k = 0; k < 3; k++) begin
            req_addr[0] = 5'(7 - 2 * k);
            tick();
        end
        req_valid = 2'b00;
        reset_n   = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_init();
        for (int a = 0; a < N; a++) issue(0, 1'b0, 5'(a), 8'h00, 64'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
